operand_fetch_unit: RTL
=======================

Name: operand_fetch_unit

Overview:
- Client-side reader for the NPC general-purpose register file.
- Accepts decoded instructions from the decode stage and drives the register-file read addresses.
- Forwards same-cycle writeback data and tracks in-flight destination registers in a scoreboard, stalling on RAW/WAW hazards.
- Presents operands to execute through a single-entry valid/ready pipeline register.

Parameters:
- ADDR_WIDTH, 5, register index width; scoreboard depth = 2^ADDR_WIDTH
- DATA_WIDTH, 32, register and PC data width

Ports:
- clk  in  1  sole clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  decode presents an instruction
- in_ready  out  1  instruction accepted this cycle when in_valid && in_ready
- in_pc  in  DATA_WIDTH  PC, passed through
- in_rs1, in_rs2  in  ADDR_WIDTH  source register indices
- in_rd  in  ADDR_WIDTH  destination index
- in_rd_wen  in  1  instruction writes in_rd
- rf_ra, rf_rb  out  ADDR_WIDTH  register-file read addresses (combinational = in_rs1/in_rs2)
- rf_busa, rf_busb  in  DATA_WIDTH  register-file combinational read data
- wb_en  in  1  writeback valid this cycle
- wb_addr  in  ADDR_WIDTH  writeback register index
- wb_data  in  DATA_WIDTH  writeback data
- flush  in  1  discard the staged instruction
- out_valid  out  1  staged instruction valid
- out_ready  in  1  execute accepts the staged instruction
- out_pc  out  DATA_WIDTH  staged PC
- out_src1, out_src2  out  DATA_WIDTH  resolved operands
- out_rd  out  ADDR_WIDTH  staged destination index
- out_rd_wen  out  1  staged destination write enable
- stall_cnt  out  32  hazard-stall cycle counter

Behaviour:
- Clocking and reset:
  - One clock (clk); reset rst is synchronous and active-high.
  - On reset: out_valid=0, out_pc/out_src1/out_src2/out_rd/out_rd_wen=0, all scoreboard bits=0, stall_cnt=0.
  - Reset mid-operation drops the staged entry and all pending bits.
- Scoreboard:
  - One pending bit per register; bit 0 is hard-wired to 0.
- Operand resolution (combinational, for source rs):
  - rs==0 -> 0
  - else if wb_en && wb_addr==rs -> wb_data (bypass, since the register file commits later in the cycle)
  - else -> rf_bus.
- Hazard (combinational), true when any of:
  - pend[rs1] && !(wb_en && wb_addr==rs1)
  - pend[rs2] && !(wb_en && wb_addr==rs2)
  - in_rd_wen && pend[rd] && !(wb_en && wb_addr==rd)   (WAW)
- in_ready = !flush && !hazard && (!out_valid || out_ready).
- Pipeline register:
  - On accept: load out_* from in_pc, the resolved operands, in_rd and in_rd_wen; out_valid=1. Latency is 1 cycle from accept to out_valid.
  - If out_valid && out_ready && no accept: out_valid=0.
  - Simultaneous drain and accept: the register reloads and out_valid stays 1.
  - out_* hold stable while out_valid && !out_ready.
- Scoreboard update:
  - wb_en && wb_addr!=0 clears pend[wb_addr].
  - Accept with in_rd_wen && in_rd!=0 sets pend[in_rd].
  - Set and clear of the same index in the same cycle: set wins.
- Flush:
  - Has priority over accept and drain.
  - Sets out_valid=0.
  - If out_valid && out_rd_wen && out_rd!=0, clears pend[out_rd]. Valid because WAW stalling guarantees the staged entry owns that bit.
  - Writeback clears in the same cycle still apply.
- stall_cnt:
  - Increments when in_valid && hazard && !flush && !rst.
  - Wraps modulo 2^32.
- No combinational path from out_ready to out_*; in_ready depends combinationally on out_ready, wb_* and flush.

Test Plan:
- Reset, then accept rs1=1, rs2=2, rd=3, with rf_busa=0x11 and rf_busb=0x22 -> next cycle out_valid=1, out_src1=0x11, out_src2=0x22, pend[3]=1.
- Back-to-back: rd=3 staged and drained, then next instruction rs1=3 with no writeback -> in_ready=0, stall_cnt increments each cycle. Then wb_en=1, wb_addr=3, wb_data=0xABCD -> accepted that cycle with out_src1=0xABCD (bypass), pend[3]=0.
- rs1=0 and rs2=0 with rf_bus=0xFFFFFFFF, and wb_en to addr 0 -> out_src1=out_src2=0, no stall. An accepted rd=0 never sets a pending bit.
- Backpressure: out_valid=1, out_ready=0 for 3 cycles -> out_* unchanged, in_ready=0. Then out_ready=1 with in_valid=1 -> drain and reload in the same cycle, out_valid stays 1.
- WAW: pend[5]=1 and new rd=5 -> stall. Cycle with wb_addr=5 and accept of rd=5 -> pend[5]=1 afterwards (set wins).
- Flush: staged rd=7, flush=1 with in_valid=1 -> out_valid=0, pend[7]=0, nothing accepted. Assert rst mid-stall -> all pending bits 0, stall_cnt=0.

Source files
------------

// File: rtl/operand_fetch_unit_if.sv
// Decode/regfile/writeback/execute bundle around the operand fetch unit.
// The slave modport is the unit itself.
interface operand_fetch_unit_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_pc;
  logic [ADDR_WIDTH-1:0] in_rs1;
  logic [ADDR_WIDTH-1:0] in_rs2;
  logic [ADDR_WIDTH-1:0] in_rd;
  logic                  in_rd_wen;
  logic [ADDR_WIDTH-1:0] rf_ra;
  logic [ADDR_WIDTH-1:0] rf_rb;
  logic [DATA_WIDTH-1:0] rf_busa;
  logic [DATA_WIDTH-1:0] rf_busb;
  logic                  wb_en;
  logic [ADDR_WIDTH-1:0] wb_addr;
  logic [DATA_WIDTH-1:0] wb_data;
  logic                  flush;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_pc;
  logic [DATA_WIDTH-1:0] out_src1;
  logic [DATA_WIDTH-1:0] out_src2;
  logic [ADDR_WIDTH-1:0] out_rd;
  logic                  out_rd_wen;
  logic [31:0]           stall_cnt;

  modport slave (
    input  in_valid, in_pc, in_rs1, in_rs2, in_rd, in_rd_wen,
    input  rf_busa, rf_busb, wb_en, wb_addr, wb_data, flush, out_ready,
    output in_ready, rf_ra, rf_rb, out_valid, out_pc, out_src1, out_src2,
    output out_rd, out_rd_wen, stall_cnt
  );

  modport master (
    output in_valid, in_pc, in_rs1, in_rs2, in_rd, in_rd_wen,
    output rf_busa, rf_busb, wb_en, wb_addr, wb_data, flush, out_ready,
    input  in_ready, rf_ra, rf_rb, out_valid, out_pc, out_src1, out_src2,
    input  out_rd, out_rd_wen, stall_cnt
  );
endinterface

// File: rtl/operand_fetch_unit.sv
// Operand fetch: regfile read with writeback bypass, scoreboard-based RAW/WAW
// stalling, and a single-entry valid/ready register toward execute.
module operand_fetch_unit #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst,
  operand_fetch_unit_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DEPTH-1:0]      r_pend;
  logic [DEPTH-1:0]      w_pend_nxt;
  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_out_pc;
  logic [DATA_WIDTH-1:0] r_out_src1;
  logic [DATA_WIDTH-1:0] r_out_src2;
  logic [ADDR_WIDTH-1:0] r_out_rd;
  logic                  r_out_rd_wen;
  logic [31:0]           r_stall_cnt;

  logic                  w_hit1, w_hit2, w_hitd;
  logic [DATA_WIDTH-1:0] w_src1, w_src2;
  logic                  w_hazard;
  logic                  w_in_ready;
  logic                  w_accept;

  assign bus.rf_ra = bus.in_rs1;
  assign bus.rf_rb = bus.in_rs2;

  // A writeback landing this cycle both supplies the operand and retires the hazard.
  assign w_hit1 = bus.wb_en && (bus.wb_addr == bus.in_rs1);
  assign w_hit2 = bus.wb_en && (bus.wb_addr == bus.in_rs2);
  assign w_hitd = bus.wb_en && (bus.wb_addr == bus.in_rd);

  assign w_src1 = (bus.in_rs1 == '0) ? '0 : (w_hit1 ? bus.wb_data : bus.rf_busa);
  assign w_src2 = (bus.in_rs2 == '0) ? '0 : (w_hit2 ? bus.wb_data : bus.rf_busb);

  assign w_hazard = (r_pend[bus.in_rs1] && !w_hit1) ||
                    (r_pend[bus.in_rs2] && !w_hit2) ||
                    (bus.in_rd_wen && r_pend[bus.in_rd] && !w_hitd);

  assign w_in_ready = !bus.flush && !w_hazard && (!r_out_valid || bus.out_ready);
  assign w_accept   = bus.in_valid && w_in_ready;

  // Clears first, then the accept's set, so a same-index set wins.
  always_comb begin
    w_pend_nxt = r_pend;
    if (bus.wb_en)
      w_pend_nxt[bus.wb_addr] = 1'b0;
    if (bus.flush && r_out_valid && r_out_rd_wen)
      w_pend_nxt[r_out_rd] = 1'b0;
    if (w_accept && bus.in_rd_wen)
      w_pend_nxt[bus.in_rd] = 1'b1;
    w_pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend       <= '0;
      r_out_valid  <= 1'b0;
      r_out_pc     <= '0;
      r_out_src1   <= '0;
      r_out_src2   <= '0;
      r_out_rd     <= '0;
      r_out_rd_wen <= 1'b0;
      r_stall_cnt  <= '0;
    end else begin
      r_pend <= w_pend_nxt;
      if (bus.in_valid && w_hazard && !bus.flush)
        r_stall_cnt <= r_stall_cnt + 32'd1;
      if (bus.flush) begin
        r_out_valid <= 1'b0;
      end else if (w_accept) begin
        r_out_valid  <= 1'b1;
        r_out_pc     <= bus.in_pc;
        r_out_src1   <= w_src1;
        r_out_src2   <= w_src2;
        r_out_rd     <= bus.in_rd;
        r_out_rd_wen <= bus.in_rd_wen;
      end else if (r_out_valid && bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_pc     = r_out_pc;
  assign bus.out_src1   = r_out_src1;
  assign bus.out_src2   = r_out_src2;
  assign bus.out_rd     = r_out_rd;
  assign bus.out_rd_wen = r_out_rd_wen;
  assign bus.stall_cnt  = r_stall_cnt;
endmodule
